// File: rtl/hdc_ctrl_pkg.sv
// Shared control definitions for the folded HDC front end: scheduler state,
// hypervector geometry and index-width helpers.
package hdc_ctrl_pkg;

  localparam int HV_DIMENSION = 2000;

  // Index width for a counter of `value` entries; never below one bit.
  function automatic int ceil_log2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  localparam int NUM_FOLDS_DEF         = 100;
  localparam int NUM_FOLDS_WIDTH_DEF   = ceil_log2(NUM_FOLDS_DEF);
  localparam int NUM_CHANNEL_DEF       = 214;
  localparam int NUM_CHANNEL_WIDTH_DEF = ceil_log2(NUM_CHANNEL_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fold_sched_state_t;

endpackage

// File: rtl/fold_chan_counter.sv
// Nested channel (inner) / fold (outer) counter with registered boundary flags.
module fold_chan_counter
  import hdc_ctrl_pkg::*;
#(
  parameter int NUM_FOLDS         = NUM_FOLDS_DEF,
  parameter int NUM_FOLDS_WIDTH   = ceil_log2(NUM_FOLDS),
  parameter int NUM_CHANNEL       = NUM_CHANNEL_DEF,
  parameter int NUM_CHANNEL_WIDTH = ceil_log2(NUM_CHANNEL)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         load,
  input  logic                         advance,
  output logic [NUM_FOLDS_WIDTH-1:0]   fold_idx,
  output logic [NUM_CHANNEL_WIDTH-1:0] chan_idx,
  output logic                         first_chan,
  output logic                         last_chan,
  output logic                         last_fold,
  output logic                         wrap_all
);

  localparam logic [NUM_FOLDS_WIDTH-1:0]   FOLD_MAX = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
  localparam logic [NUM_CHANNEL_WIDTH-1:0] CHAN_MAX = NUM_CHANNEL_WIDTH'(NUM_CHANNEL - 1);

  logic [NUM_FOLDS_WIDTH-1:0]   fold_q, fold_d;
  logic [NUM_CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic                         first_q, first_d;
  logic                         last_chan_q, last_chan_d;
  logic                         last_fold_q, last_fold_d;
  logic                         chan_at_max, fold_at_max;

  assign chan_at_max = (chan_q == CHAN_MAX);
  assign fold_at_max = (fold_q == FOLD_MAX);
  assign wrap_all    = advance && chan_at_max && fold_at_max;

  always_comb begin
    fold_d      = fold_q;
    chan_d      = chan_q;
    first_d     = first_q;
    last_chan_d = last_chan_q;
    last_fold_d = last_fold_q;
    if (clear) begin
      fold_d      = '0;
      chan_d      = '0;
      first_d     = 1'b0;
      last_chan_d = 1'b0;
      last_fold_d = 1'b0;
    end else if (load) begin
      fold_d      = '0;
      chan_d      = '0;
      first_d     = 1'b1;
      last_chan_d = (NUM_CHANNEL == 1);
      last_fold_d = (NUM_FOLDS == 1);
    end else if (advance) begin
      if (chan_at_max) begin
        chan_d = '0;
        fold_d = fold_q + 1'b1;
      end else begin
        chan_d = chan_q + 1'b1;
      end
      // Flags describe the beat that will be presented next.
      first_d     = (chan_d == '0);
      last_chan_d = (chan_d == CHAN_MAX);
      last_fold_d = (fold_d == FOLD_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fold_q      <= '0;
      chan_q      <= '0;
      first_q     <= 1'b0;
      last_chan_q <= 1'b0;
      last_fold_q <= 1'b0;
    end else begin
      fold_q      <= fold_d;
      chan_q      <= chan_d;
      first_q     <= first_d;
      last_chan_q <= last_chan_d;
      last_fold_q <= last_fold_d;
    end
  end

  assign fold_idx   = fold_q;
  assign chan_idx   = chan_q;
  assign first_chan = first_q;
  assign last_chan  = last_chan_q;
  assign last_fold  = last_fold_q;

endmodule

// File: rtl/fold_scheduler.sv
// Sequences one sample through every (fold, channel) step beat, then waits for pipe_done.
// Optional performance counters are enabled with FOLD_SCHED_PERF_EN.
module fold_scheduler
  import hdc_ctrl_pkg::*;
#(
  parameter int NUM_FOLDS         = NUM_FOLDS_DEF,
  parameter int NUM_FOLDS_WIDTH   = ceil_log2(NUM_FOLDS),
  parameter int NUM_CHANNEL       = NUM_CHANNEL_DEF,
  parameter int NUM_CHANNEL_WIDTH = ceil_log2(NUM_CHANNEL)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_valid,
  output logic                         start_ready,
  output logic                         step_valid,
  input  logic                         step_ready,
  output logic [NUM_FOLDS_WIDTH-1:0]   fold_idx,
  output logic [NUM_CHANNEL_WIDTH-1:0] chan_idx,
  output logic                         first_chan,
  output logic                         last_chan,
  output logic                         last_fold,
  input  logic                         pipe_done,
  output logic                         busy,
  output logic                         done,
  output fold_sched_state_t            state_dbg
`ifdef FOLD_SCHED_PERF_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  sample_cycles
`endif
);

  // Handshake: a beat transfers on any rising edge where step_valid && step_ready;
  // step_valid and the index/flag outputs stay frozen until that happens.

  fold_sched_state_t state_q, state_d;
  logic step_valid_q, step_valid_d;
  logic done_q, done_d;
  logic start_fire, beat_fire;
  logic cnt_load, cnt_advance, wrap_all;

  assign start_fire = (state_q == IDLE) && start_valid;
  assign beat_fire  = step_valid_q && step_ready;

  always_comb begin
    state_d      = state_q;
    step_valid_d = step_valid_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_advance  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_fire) begin
          state_d      = RUN;
          step_valid_d = 1'b1;
          cnt_load     = 1'b1;
        end
      end
      RUN: begin
        if (beat_fire) begin
          cnt_advance = 1'b1;
          if (wrap_all) begin
            state_d      = FLUSH;
            step_valid_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (pipe_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        step_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      step_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_valid_q <= step_valid_d;
      done_q       <= done_d;
    end
  end

  // The final accepted beat also returns the counters to zero.
  fold_chan_counter #(
    .NUM_FOLDS         (NUM_FOLDS),
    .NUM_FOLDS_WIDTH   (NUM_FOLDS_WIDTH),
    .NUM_CHANNEL       (NUM_CHANNEL),
    .NUM_CHANNEL_WIDTH (NUM_CHANNEL_WIDTH)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (wrap_all),
    .load       (cnt_load),
    .advance    (cnt_advance),
    .fold_idx   (fold_idx),
    .chan_idx   (chan_idx),
    .first_chan (first_chan),
    .last_chan  (last_chan),
    .last_fold  (last_fold),
    .wrap_all   (wrap_all)
  );

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign step_valid  = step_valid_q;
  assign done        = done_q;
  assign state_dbg   = state_q;

`ifdef FOLD_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] sample_q, sample_d;

  always_comb begin
    stall_d  = stall_q;
    sample_d = sample_q;
    if (start_fire) begin
      stall_d  = '0;
      sample_d = '0;
    end else begin
      if ((state_q == RUN) && step_valid_q && !step_ready && (stall_q != '1))
        stall_d = stall_q + 32'd1;
      if ((state_q != IDLE) && (sample_q != '1))
        sample_d = sample_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      sample_q <= '0;
    end else begin
      stall_q  <= stall_d;
      sample_q <= sample_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign sample_cycles = sample_q;
`endif

endmodule

// File: tb/tb_fold_scheduler.sv
// Scoreboard bench for fold_scheduler: a 4x3 instance for the main sequences
// and a 1x1 instance for the degenerate geometry.
module tb_fold_scheduler;
  import hdc_ctrl_pkg::*;

  localparam int NF = 4;
  localparam int NC = 3;
  localparam int FW = 2;
  localparam int CW = 2;
  localparam int BW = FW + CW + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main instance
  logic start_valid, start_ready, step_valid, step_ready;
  logic [FW-1:0] fold_idx;
  logic [CW-1:0] chan_idx;
  logic first_chan, last_chan, last_fold, pipe_done, busy, done;
  fold_sched_state_t state_dbg;
`ifdef FOLD_SCHED_PERF_EN
  logic [31:0] stall_cycles, sample_cycles;
`endif

  // degenerate 1x1 instance
  logic s1_start_valid, s1_start_ready, s1_step_valid, s1_step_ready;
  logic [0:0] s1_fold_idx, s1_chan_idx;
  logic s1_first_chan, s1_last_chan, s1_last_fold, s1_pipe_done, s1_busy, s1_done;
  fold_sched_state_t s1_state_dbg;
`ifdef FOLD_SCHED_PERF_EN
  logic [31:0] s1_stall_cycles, s1_sample_cycles;
`endif

  fold_scheduler #(.NUM_FOLDS(NF), .NUM_CHANNEL(NC)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .step_valid(step_valid), .step_ready(step_ready),
    .fold_idx(fold_idx), .chan_idx(chan_idx),
    .first_chan(first_chan), .last_chan(last_chan), .last_fold(last_fold),
    .pipe_done(pipe_done), .busy(busy), .done(done), .state_dbg(state_dbg)
`ifdef FOLD_SCHED_PERF_EN
    , .stall_cycles(stall_cycles), .sample_cycles(sample_cycles)
`endif
  );

  fold_scheduler #(.NUM_FOLDS(1), .NUM_CHANNEL(1)) dut1 (
    .clk(clk), .rst(rst),
    .start_valid(s1_start_valid), .start_ready(s1_start_ready),
    .step_valid(s1_step_valid), .step_ready(s1_step_ready),
    .fold_idx(s1_fold_idx), .chan_idx(s1_chan_idx),
    .first_chan(s1_first_chan), .last_chan(s1_last_chan), .last_fold(s1_last_fold),
    .pipe_done(s1_pipe_done), .busy(s1_busy), .done(s1_done), .state_dbg(s1_state_dbg)
`ifdef FOLD_SCHED_PERF_EN
    , .stall_cycles(s1_stall_cycles), .sample_cycles(s1_sample_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  int beat_cnt   = 0;
  int done_cnt   = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Beats are sampled mid-cycle, away from the rising edge that transfers them.
  always @(negedge clk) begin
    if (rst) begin
      if (step_valid && step_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("beat_extra", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat", 32'({fold_idx, chan_idx, first_chan, last_chan, last_fold}), 32'(mon_exp));
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample();
    for (int f = 0; f < NF; f++) begin
      for (int c = 0; c < NC; c++) begin
        exp_q.push_back({FW'(f), CW'(c), (c == 0), (c == NC - 1), (f == NF - 1)});
      end
    end
  endtask

  task automatic start_sample();
    check("start_ready_before_start", 32'(start_ready), 32'd1);
    push_sample();
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_run_end();
    int n;
    n = 0;
    while (step_valid && n < 100) begin
      tick();
      n++;
    end
    check("run_end_timeout", 32'(step_valid), 32'd0);
  endtask

  task automatic flush_done();
    pipe_done = 1'b1;
    tick();
    pipe_done = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("start_ready_with_done", 32'(start_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int b0, d0;

  initial begin
    rst = 1'b1;
    start_valid = 1'b0; step_ready = 1'b0; pipe_done = 1'b0;
    s1_start_valid = 1'b0; s1_step_ready = 1'b0; s1_pipe_done = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset_outputs",
          32'({step_valid, start_ready, busy, done, fold_idx, chan_idx, first_chan, last_chan, last_fold}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 7'd0}));
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    tick();
    rst = 1'b1;
    tick();

    // full sample, consecutive beats
    step_ready = 1'b1;
    b0 = beat_cnt;
    d0 = done_cnt;
    start_sample();
    for (int i = 0; i < NF * NC; i++) begin
      check("valid_during_run", 32'(step_valid), 32'd1);
      check("busy_during_run", 32'(busy), 32'd1);
      tick();
    end
    check("valid_after_last", 32'(step_valid), 32'd0);
    check("flush_state", 32'(state_dbg), 32'(FLUSH));
    check("flush_start_ready", 32'(start_ready), 32'd0);
    check("beats_sample1", 32'(beat_cnt - b0), 32'(NF * NC));
    check("queue_empty1", 32'(exp_q.size()), 32'd0);
    repeat (7) tick();
    check("flush_hold", 32'({busy, step_valid}), 32'b10);
    check("no_early_done", 32'(done_cnt - d0), 32'd0);
    flush_done();

    // start in the done cycle, stall at (1,1), stray pipe_done/start_valid in RUN
    b0 = beat_cnt;
    start_sample();
    check("done_one_cycle", 32'(done), 32'd0);
    check("restart_first_beat", 32'({step_valid, fold_idx, chan_idx, first_chan}), 32'b1_00_00_1);
    repeat (4) tick();
    check("at_beat_1_1", 32'({fold_idx, chan_idx}), 32'b01_01);
    step_ready = 1'b0;
    repeat (5) begin
      tick();
      check("stall_hold", 32'({step_valid, fold_idx, chan_idx}), 32'b1_01_01);
    end
    step_ready = 1'b1;
    repeat (2) tick();
    check("at_beat_2_0", 32'({fold_idx, chan_idx}), 32'b10_00);
    d0 = done_cnt;
    pipe_done = 1'b1;
    start_valid = 1'b1;
    tick();
    pipe_done = 1'b0;
    start_valid = 1'b0;
    check("run_ignores_pipe_done", 32'({busy, step_valid, done}), 32'b110);
    wait_run_end();
    check("beats_sample2", 32'(beat_cnt - b0), 32'(NF * NC));
    check("queue_empty2", 32'(exp_q.size()), 32'd0);
    check("no_done_from_run_pulse", 32'(done_cnt - d0), 32'd0);
`ifdef FOLD_SCHED_PERF_EN
    check("stall_cycles", stall_cycles, 32'd5);
`endif
    flush_done();

    // pipe_done while idle
    tick();
    d0 = done_cnt;
    pipe_done = 1'b1;
    tick();
    pipe_done = 1'b0;
    repeat (3) tick();
    check("idle_ignores_pipe_done", 32'(done_cnt - d0), 32'd0);
    check("idle_state", 32'({busy, start_ready}), 32'b01);

    // asynchronous reset at beat (2,1)
    start_sample();
    repeat (7) tick();
    check("at_beat_2_1", 32'({fold_idx, chan_idx}), 32'b10_01);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({step_valid, start_ready, busy, done, fold_idx, chan_idx, first_chan, last_chan, last_fold}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 7'd0}));
    exp_q.delete();
    d0 = done_cnt;
    tick();
    rst = 1'b1;
    tick();
    b0 = beat_cnt;
    start_sample();
    wait_run_end();
    check("beats_after_reset", 32'(beat_cnt - b0), 32'(NF * NC));
    check("queue_empty3", 32'(exp_q.size()), 32'd0);
    check("no_stale_done", 32'(done_cnt - d0), 32'd0);
    flush_done();

    // degenerate 1x1 geometry
    s1_step_ready = 1'b1;
    check("s1_start_ready", 32'(s1_start_ready), 32'd1);
    s1_start_valid = 1'b1;
    tick();
    s1_start_valid = 1'b0;
    check("s1_single_beat",
          32'({s1_step_valid, s1_fold_idx, s1_chan_idx, s1_first_chan, s1_last_chan, s1_last_fold}),
          32'b1_0_0_111);
    tick();
    check("s1_flush", 32'({s1_step_valid, s1_busy, s1_start_ready}), 32'b010);
    s1_pipe_done = 1'b1;
    tick();
    s1_pipe_done = 1'b0;
    check("s1_done", 32'({s1_done, s1_start_ready}), 32'b11);
    tick();
    check("s1_done_clears", 32'(s1_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fold_scheduler.md
Name: fold_scheduler

Overview:
- Sequences the folded HDC front end (hv_generator → spatial_encoder → fuser) for one feature sample.
- Walks every (fold, channel) pair in a fixed order and issues one indexed step beat per pair on a valid/ready handshake.
- Flags the channel/fold boundaries the encoder needs to clear and threshold its accumulators.
- Blocks the next sample until the fuser reports that the full hypervector has been assembled.

Parameters:
- NUM_FOLDS, 100, number of folds per hypervector (2000 / FOLD_WIDTH)
- NUM_FOLDS_WIDTH, 7, width of fold index, ceilLog2(NUM_FOLDS)
- NUM_CHANNEL, 214, feature channels per sample
- NUM_CHANNEL_WIDTH, 8, width of channel index, ceilLog2(NUM_CHANNEL)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- start_valid  in  1  new sample latched upstream and ready to encode
- start_ready  out  1  scheduler idle and accepting start
- step_valid  out  1  step beat valid
- step_ready  in  1  datapath accepts beat
- fold_idx  out  NUM_FOLDS_WIDTH  fold of current beat
- chan_idx  out  NUM_CHANNEL_WIDTH  channel of current beat
- first_chan  out  1  chan_idx == 0 (accumulator clear)
- last_chan  out  1  chan_idx == NUM_CHANNEL-1 (threshold/emit fold)
- last_fold  out  1  fold_idx == NUM_FOLDS-1
- pipe_done  in  1  single-cycle pulse from fuser: full HV assembled
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the sample completes

Behaviour:
- States: IDLE, RUN, FLUSH.
- Reset (asynchronous, rst=0): state=IDLE; fold/channel counters = 0; step_valid, done, busy = 0; start_ready = 1; index and flag outputs = 0.
- All outputs are registered except start_ready and busy, which decode state.
- IDLE:
  - start_ready = 1.
  - start_valid sampled high at edge T → RUN; step_valid = 1 from T+1 with fold 0, chan 0, first_chan = 1.
- RUN:
  - Beat order: chan_idx is the inner loop and fold_idx the outer loop: (0,0),(0,1)…(0,NC-1),(1,0)…(NF-1,NC-1).
  - A beat transfers when step_valid && step_ready.
  - While step_valid && !step_ready, indices and flags hold stable. step_valid is never retracted until the beat is accepted.
  - With step_ready held at 1, one beat transfers per cycle: NUM_FOLDS*NUM_CHANNEL consecutive cycles.
  - Channel wrap: after an accepted beat with chan = NC-1, chan returns to 0 and fold increments.
  - When the beat with last_fold && last_chan is accepted: step_valid drops the next cycle, state → FLUSH, counters clear to 0.
- FLUSH:
  - step_valid = 0, start_ready = 0.
  - pipe_done high at edge T → IDLE; done = 1 for cycle T+1 only.
  - start_ready = 1 from T+1, so a start may be accepted in the same cycle done is high.
- pipe_done in IDLE or RUN is ignored: no state change, no done.
- start_valid outside IDLE is ignored; it is not queued.
- Degenerate sizes: NUM_FOLDS = 1 and/or NUM_CHANNEL = 1 must work; first_chan and last_chan may both be high on the same beat.
- Reset mid-RUN or mid-FLUSH: immediate return to IDLE state. The in-flight sample is abandoned and no done pulse is produced.

Optional Feature:
- Macro: FOLD_SCHED_PERF_EN.
- When defined, add outputs:
  - stall_cycles (32 bits): counts cycles with step_valid && !step_ready during RUN.
  - sample_cycles (32 bits): counts cycles from start acceptance to done.
- Both counters clear on start acceptance, saturate at all-ones, hold after done, and reset to 0.
- When not defined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package hdc_ctrl_pkg holds:
  - state enum fold_sched_state_t {IDLE, RUN, FLUSH}
  - localparam HV_DIMENSION = 2000
  - widths and defaults for NUM_FOLDS and NUM_CHANNEL, derived with ceilLog2
- Natural sub-module: fold_chan_counter, the nested channel/fold counter.
  - Inputs: clear, advance.
  - Outputs: indices, first_chan, last_chan, last_fold, wrap_all.
  - Instantiated once.

Test Plan (bench overrides NUM_FOLDS=4, NUM_CHANNEL=3):
- Reset, then start pulse with step_ready=1 → 12 beats on consecutive cycles in order (0,0)…(3,2); first_chan on beats 0,3,6,9; last_fold on beats 9–11; step_valid low after beat 11; busy=1 throughout.
- Hold step_ready=0 for 5 cycles at beat (1,1) → indices held unchanged, no beat lost or duplicated; stall_cycles = 5 with FOLD_SCHED_PERF_EN.
- In FLUSH, wait 7 cycles then pulse pipe_done → done pulses exactly one cycle later; start_ready rises that same cycle; start accepted that cycle → next step beat (0,0) the following cycle.
- pipe_done pulsed in IDLE and at beat (2,0) of RUN → no done, sequence unaffected; start_valid during RUN → ignored, exactly 12 beats.
- Drive rst=0 asynchronously at beat (2,1) → outputs reach reset values without a clock edge; after release, start runs the full 12 beats from (0,0) with no stale done.
- NUM_FOLDS=1, NUM_CHANNEL=1 → single beat with first_chan=last_chan=last_fold=1, then FLUSH.
